// File: rtl/player_position.sv
// -----------------------------------------------------------------------------
// player_position
//   Registers the next horizontal player X coordinate once per enabled clock.
//   The incoming X is clamped to [MIN_X, MAX_X]. A single pressed button moves
//   it by STEP toward that limit, saturating at the limit. When neither or
//   both buttons are pressed, the clamped X is registered unchanged. The owner
//   of the position state feeds o_PlayerPosition back into i_Player_Position.
//
// Ports
//   i_Clk              system clock, rising edge
//   i_Rst              asynchronous active-high reset -> INIT_X
//   i_Btn_Left         level, move toward MIN_X
//   i_Btn_Right        level, move toward MAX_X
//   i_Player_Position  current X (unsigned, 10 bits)
//   i_fTick            level enable; the register holds while low
//   o_PlayerPosition   registered next X (unsigned, 10 bits)
// -----------------------------------------------------------------------------
module player_position #(
  parameter int STEP   = 4,
  parameter int MIN_X  = 0,
  parameter int MAX_X  = 616,
  parameter int INIT_X = 320
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Btn_Left,
  input  logic       i_Btn_Right,
  input  logic [9:0] i_Player_Position,
  input  logic       i_fTick,
  output logic [9:0] o_PlayerPosition
);

  localparam logic [9:0]  MIN_P  = 10'(MIN_X);
  localparam logic [9:0]  MAX_P  = 10'(MAX_X);
  localparam logic [9:0]  STEP_P = 10'(STEP);
  localparam logic [9:0]  INIT_P = 10'(INIT_X);
  localparam logic [10:0] MAX_W  = 11'(MAX_X);
  localparam logic [10:0] STEP_W = 11'(STEP);

  logic [9:0]  base;
  logic [9:0]  next_x;
  logic [10:0] sum_w;
  logic        mv_left;
  logic        mv_right;

  // Clamp the fed-back coordinate so that a corrupt input cannot escape the field.
  always_comb begin
    base = i_Player_Position;
    if (i_Player_Position < MIN_P)      base = MIN_P;
    else if (i_Player_Position > MAX_P) base = MAX_P;
  end

  // When both buttons are pressed, they cancel. Neither button has priority.
  assign mv_left  = i_Btn_Left & ~i_Btn_Right;
  assign mv_right = i_Btn_Right & ~i_Btn_Left;

  // Widen by one bit so that base + STEP cannot wrap before the limit check.
  assign sum_w = {1'b0, base} + STEP_W;

  always_comb begin
    next_x = base;
    if (mv_left) begin
      // Check the remaining room first. The subtraction then never drops below MIN_X.
      if (base - MIN_P >= STEP_P) next_x = base - STEP_P;
      else                        next_x = MIN_P;
    end else if (mv_right) begin
      if (sum_w <= MAX_W) next_x = sum_w[9:0];
      else                next_x = MAX_P;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst)        o_PlayerPosition <= INIT_P;
    else if (i_fTick) o_PlayerPosition <= next_x;
  end

endmodule

// File: tb/tb_player_position.sv
module tb_player_position;

  logic       clk;
  logic       rst;
  logic       btn_l;
  logic       btn_r;
  logic [9:0] pos_in;
  logic       tick;
  logic [9:0] pos_out;

  int checks;
  int failures;

  player_position dut (
    .i_Clk            (clk),
    .i_Rst            (rst),
    .i_Btn_Left       (btn_l),
    .i_Btn_Right      (btn_r),
    .i_Player_Position(pos_in),
    .i_fTick          (tick),
    .o_PlayerPosition (pos_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stop a runaway simulation.
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    // Drive the inputs with values that would otherwise move the position.
    @(negedge clk);
    btn_l = 1'b0; btn_r = 1'b1; pos_in = 10'd500; tick = 1'b1;
    rst = 1'b1;
    #1;
    checks++;
    if (pos_out !== 10'd320) begin
      failures++;
      $display("FAIL reset_async: got %0d expected 320", pos_out);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (pos_out !== 10'd320) begin
        failures++;
        $display("FAIL reset_hold cyc%0d: got %0d expected 320", i, pos_out);
      end
    end
    // Release the reset with the tick low. The output must stay at INIT_X.
    @(negedge clk);
    tick = 1'b0; rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (pos_out !== 10'd320) begin
        failures++;
        $display("FAIL reset_release cyc%0d: got %0d expected 320", i, pos_out);
      end
    end
  endtask

  task automatic test_left();
    @(negedge clk);
    pos_in = 10'd320; btn_l = 1'b1; btn_r = 1'b0; tick = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (pos_out !== 10'd316) begin
      failures++;
      $display("FAIL left_one: got %0d expected 316", pos_out);
    end
    // Hold the button for 3 enabled cycles, starting from 320 with the output fed back.
    @(negedge clk);
    pos_in = 10'd320;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      pos_in = pos_out;
    end
    checks++;
    if (pos_out !== 10'd308) begin
      failures++;
      $display("FAIL left_held3: got %0d expected 308", pos_out);
    end
    @(negedge clk);
    btn_l = 1'b0; tick = 1'b0;
  endtask

  task automatic test_right();
    @(negedge clk);
    pos_in = 10'd320; btn_l = 1'b0; btn_r = 1'b1; tick = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (pos_out !== 10'd324) begin
      failures++;
      $display("FAIL right_one: got %0d expected 324", pos_out);
    end
    @(negedge clk);
    pos_in = 10'd320; btn_l = 1'b1; btn_r = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (pos_out !== 10'd320) begin
      failures++;
      $display("FAIL both_buttons: got %0d expected 320", pos_out);
    end
    @(negedge clk);
    pos_in = 10'd77; btn_l = 1'b0; btn_r = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (pos_out !== 10'd77) begin
      failures++;
      $display("FAIL no_button: got %0d expected 77", pos_out);
    end
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic test_saturation();
    logic [9:0] in_v  [9] = '{10'd0, 10'd2, 10'd4, 10'd616, 10'd614, 10'd612,
                              10'd1000, 10'd1023, 10'd1023};
    logic       l_v   [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       r_v   [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [9:0] exp_v [9] = '{10'd0, 10'd0, 10'd0, 10'd616, 10'd616, 10'd616,
                              10'd616, 10'd612, 10'd616};
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      pos_in = in_v[i]; btn_l = l_v[i]; btn_r = r_v[i]; tick = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (pos_out !== exp_v[i]) begin
        failures++;
        $display("FAIL sat[%0d] in=%0d L=%0b R=%0b: got %0d expected %0d",
                 i, in_v[i], l_v[i], r_v[i], pos_out, exp_v[i]);
      end
    end
    @(negedge clk);
    btn_l = 1'b0; btn_r = 1'b0; tick = 1'b0;
  endtask

  task automatic test_tick_gating();
    @(negedge clk);
    pos_in = 10'd200; btn_l = 1'b0; btn_r = 1'b0; tick = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (pos_out !== 10'd200) begin
      failures++;
      $display("FAIL gate_setup: got %0d expected 200", pos_out);
    end
    @(negedge clk);
    tick = 1'b0; pos_in = 10'd100;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      btn_l = i[0]; btn_r = ~i[0];
      @(posedge clk); #1;
      checks++;
      if (pos_out !== 10'd200) begin
        failures++;
        $display("FAIL gate_hold cyc%0d: got %0d expected 200", i, pos_out);
      end
    end
    @(negedge clk);
    btn_l = 1'b0; btn_r = 1'b0; tick = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (pos_out !== 10'd100) begin
      failures++;
      $display("FAIL gate_release: got %0d expected 100", pos_out);
    end
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    pos_in = 10'd500; btn_l = 1'b0; btn_r = 1'b0; tick = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (pos_out !== 10'd500) begin
      failures++;
      $display("FAIL midrst_setup: got %0d expected 500", pos_out);
    end
    // Hold Right with the tick high, then pulse the reset between clock edges.
    @(negedge clk);
    btn_r = 1'b1;
    rst = 1'b1;
    #1;
    checks++;
    if (pos_out !== 10'd320) begin
      failures++;
      $display("FAIL midrst_async: got %0d expected 320", pos_out);
    end
    rst = 1'b0;
    pos_in = pos_out;
    @(posedge clk); #1;
    checks++;
    if (pos_out !== 10'd324) begin
      failures++;
      $display("FAIL midrst_resume: got %0d expected 324", pos_out);
    end
    @(negedge clk);
    btn_r = 1'b0; tick = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    btn_l    = 1'b0;
    btn_r    = 1'b0;
    pos_in   = 10'd0;
    tick     = 1'b0;

    test_reset();
    test_left();
    test_right();
    test_saturation();
    test_tick_gating();
    test_reset_mid_run();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/player_position.md
# player_position

Horizontal player-position update block for the game datapath. Once per frame tick it takes the current player X coordinate and the left/right button levels, and registers the next X coordinate. The next X is moved by a fixed step and saturated to the playfield limits. It sits between the button inputs and the renderer/collision logic. The owner of the position state feeds `o_PlayerPosition` back into `i_Player_Position`.

## Interface
Parameters:
- `STEP`, default 4: pixels moved per qualifying tick.
- `MIN_X`, default 0: leftmost legal X coordinate.
- `MAX_X`, default 616: rightmost legal X coordinate (640-pixel screen minus 24-pixel sprite width).
- `INIT_X`, default 320: reset position.

Ports (one clock; reset is asynchronous and active-high):
- `i_Clk`  in  1  system clock; all state updates on its rising edge.
- `i_Rst`  in  1  asynchronous, active-high reset.
- `i_Btn_Left`  in  1  level; 1 requests a move toward `MIN_X`.
- `i_Btn_Right`  in  1  level; 1 requests a move toward `MAX_X`.
- `i_Player_Position`  in  10  current X coordinate, unsigned.
- `i_fTick`  in  1  frame-update enable, level-sensitive.
- `o_PlayerPosition`  out  10  registered next X coordinate, unsigned.

## Operation
- Sanitize the input first: `base = min(max(i_Player_Position, MIN_X), MAX_X)`.
- Compute the next value from the buttons:
  - Left only: `next = (base - MIN_X >= STEP) ? base - STEP : MIN_X`.
  - Right only: `next = (MAX_X - base >= STEP) ? base + STEP : MAX_X`.
  - Neither or both pressed: `next = base` (no movement; neither button has priority).
- Arithmetic rules:
  - Compare before subtracting so the 10-bit value never wraps below 0.
  - Use an 11-bit intermediate for the addition so values above 1023 never wrap.
- On a rising clock edge with `i_fTick = 1`: `o_PlayerPosition <= next`.
- On a rising clock edge with `i_fTick = 0`: `o_PlayerPosition` holds its value; buttons and `i_Player_Position` are ignored.
- `i_fTick` is a level enable, not edge-detected. If it stays high for N cycles with a button held, the position moves once per cycle, because the owner re-feeds the output. Frame-rate pacing is the upstream tick generator's job.
- No internal state other than the output register; no button debouncing or synchronization. Inputs are assumed to be synchronous to `i_Clk`.

## Timing
- Reset: `o_PlayerPosition = INIT_X` (320) immediately on `i_Rst` assertion, independent of the clock. It holds 320 while `i_Rst = 1`, and the first update occurs on the first rising edge after deassertion with `i_fTick = 1`.
- Reset mid-operation overrides any update in progress; no partial move survives.
- Latency is 1 cycle: the inputs sampled at edge k appear on `o_PlayerPosition` after edge k.
- Movement per enabled edge is at most `STEP`, never overshoots `MIN_X`/`MAX_X`, and is idempotent at the limits.
- A button change while `i_fTick = 0` has no effect. A button change while `i_fTick = 1` takes effect on the next edge.

## Test plan
- Reset: assert `i_Rst` with the clock running and inputs arbitrary → output is 320 asynchronously; it stays 320 after release until `i_fTick = 1`.
- Left move: in=320, `i_fTick = 1`, Left=1 for one cycle → output 316. Left held for 3 enabled cycles with output fed back → 308.
- Right move: in=320, `i_fTick = 1`, Right=1 for one cycle → output 324. Both buttons pressed → output 320.
- Saturation:
  - in=0, Left, tick → 0.
  - in=2, Left, tick → 0.
  - in=616, Right, tick → 616.
  - in=614, Right, tick → 616.
  - in=1000, no button, tick → 616 (sanitized).
- Tick gating: `i_fTick = 0`, toggle Left/Right and change in=100 for 10 cycles → output unchanged. Then raise `i_fTick` with no button → output 100 after 1 cycle.
- Reset mid-run: output at 500 with Right held and tick high; pulse `i_Rst` between edges → output 320 immediately. Movement resumes from the fed-back 320 to 324 on the next enabled edge.
